multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: Moore FSM with per-state datapath controls,
// opcode-driven immediate select and ALU decoder.
module multicycle_control (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] OP,
  input  logic [2:0] FUNCT3,
  input  logic       FUNCT7B5,
  input  logic       ZERO,
  output logic       PCWRITE,
  output logic       ADRSRC,
  output logic       MEMWRITE,
  output logic       IRWRITE,
  output logic       REGWRITE,
  output logic [1:0] RESULTSRC,
  output logic [1:0] ALUSRCA,
  output logic [1:0] ALUSRCB,
  output logic [1:0] IMMSRC,
  output logic [2:0] ALUCONTROL,
  output logic [3:0] STATE,
  output logic       DONE,
  output logic       ILLEGAL
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd  = 2'd0,
    AluOpSub  = 2'd1,
    AluOpFunc = 2'd2,
    AluOpNone = 2'd3
  } alu_op_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  state_e  state_q, state_d;
  state_e  cur_st;
  alu_op_e alu_op;
  logic    illegal_op;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign illegal_op = !(OP inside {OpLoad, OpStore, OpRType, OpIType, OpBeq, OpJal});

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (OP)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (OP == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // Reset presents FETCH selects with every enable held low.
  assign cur_st = RST_N ? state_q : StFetch;
  assign STATE  = cur_st;

  always_comb begin
    PCWRITE   = 1'b0;
    ADRSRC    = 1'b0;
    MEMWRITE  = 1'b0;
    IRWRITE   = 1'b0;
    REGWRITE  = 1'b0;
    RESULTSRC = 2'b00;
    ALUSRCA   = 2'b00;
    ALUSRCB   = 2'b00;
    DONE      = 1'b0;
    ILLEGAL   = 1'b0;
    alu_op    = AluOpNone;
    case (cur_st)
      StFetch: begin
        IRWRITE   = 1'b1;
        ALUSRCB   = 2'b10;
        alu_op    = AluOpAdd;
        RESULTSRC = 2'b10;
        PCWRITE   = 1'b1;
      end
      StDecode: begin
        ALUSRCA = 2'b01;
        ALUSRCB = 2'b01;
        alu_op  = AluOpAdd;
        ILLEGAL = illegal_op;
      end
      StMemAdr: begin
        ALUSRCA = 2'b10;
        ALUSRCB = 2'b01;
        alu_op  = AluOpAdd;
      end
      StMemRead: ADRSRC = 1'b1;
      StMemWb: begin
        RESULTSRC = 2'b01;
        REGWRITE  = 1'b1;
        DONE      = 1'b1;
      end
      StMemWrite: begin
        ADRSRC   = 1'b1;
        MEMWRITE = 1'b1;
        DONE     = 1'b1;
      end
      StExecuteR: begin
        ALUSRCA = 2'b10;
        alu_op  = AluOpFunc;
      end
      StExecuteI: begin
        ALUSRCA = 2'b10;
        ALUSRCB = 2'b01;
        alu_op  = AluOpFunc;
      end
      StAluWb: begin
        REGWRITE = 1'b1;
        DONE     = 1'b1;
      end
      StBeq: begin
        ALUSRCA = 2'b10;
        alu_op  = AluOpSub;
        PCWRITE = ZERO;
        DONE    = 1'b1;
      end
      StJal: begin
        ALUSRCA = 2'b01;
        ALUSRCB = 2'b10;
        alu_op  = AluOpAdd;
        PCWRITE = 1'b1;
        DONE    = 1'b1;
      end
      default: ;
    endcase
    if (!RST_N) begin
      PCWRITE  = 1'b0;
      IRWRITE  = 1'b0;
      MEMWRITE = 1'b0;
      REGWRITE = 1'b0;
      DONE     = 1'b0;
      ILLEGAL  = 1'b0;
    end
  end

  always_comb begin
    case (OP)
      OpStore: IMMSRC = 2'b01;
      OpBeq:   IMMSRC = 2'b10;
      OpJal:   IMMSRC = 2'b11;
      default: IMMSRC = 2'b00;
    endcase
  end

  always_comb begin
    ALUCONTROL = 3'b000;
    case (alu_op)
      AluOpSub:  ALUCONTROL = 3'b001;
      AluOpFunc: begin
        case (FUNCT3)
          // Subtract only for R-type (OP[5]) with funct7[5] set.
          3'b000:  ALUCONTROL = (OP[5] && FUNCT7B5) ? 3'b001 : 3'b000;
          3'b010:  ALUCONTROL = 3'b101;
          3'b110:  ALUCONTROL = 3'b011;
          3'b111:  ALUCONTROL = 3'b010;
          default: ALUCONTROL = 3'b000;
        endcase
      end
      default: ALUCONTROL = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level state-sequence model plus per-state
// output table, checked every negedge, with a few hand-computed literal expectations.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] OP;
  logic [2:0] FUNCT3;
  logic       FUNCT7B5;
  logic       ZERO;
  logic       PCWRITE, ADRSRC, MEMWRITE, IRWRITE, REGWRITE;
  logic [1:0] RESULTSRC, ALUSRCA, ALUSRCB, IMMSRC;
  logic [2:0] ALUCONTROL;
  logic [3:0] STATE;
  logic       DONE, ILLEGAL;

  multicycle_control dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .OP         (OP),
    .FUNCT3     (FUNCT3),
    .FUNCT7B5   (FUNCT7B5),
    .ZERO       (ZERO),
    .PCWRITE    (PCWRITE),
    .ADRSRC     (ADRSRC),
    .MEMWRITE   (MEMWRITE),
    .IRWRITE    (IRWRITE),
    .REGWRITE   (REGWRITE),
    .RESULTSRC  (RESULTSRC),
    .ALUSRCA    (ALUSRCA),
    .ALUSRCB    (ALUSRCB),
    .IMMSRC     (IMMSRC),
    .ALUCONTROL (ALUCONTROL),
    .STATE      (STATE),
    .DONE       (DONE),
    .ILLEGAL    (ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] state;
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] aluc;
    logic       done, ill;
  } exp_t;

  int   n_total  = 0;
  int   n_passed = 0;
  int   exp_state = 0;
  bit   chk_en    = 1'b0;
  exp_t e_cur;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0h expected %0h (model state %0d)", name, $time, act,
               exp, exp_state);
    end else begin
      n_passed++;
    end
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                      7'b1101111};
  endfunction

  // Output table keyed by state number; reset shows FETCH with enables off.
  function automatic exp_t model(input int s_in, input logic rst_n, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7b5, input logic zero);
    exp_t e;
    int   s;
    bit   on;
    s  = rst_n ? s_in : 0;
    on = rst_n;
    e  = '0;
    e.state = 4'(s);
    if (op == 7'b0100011)      e.imm = 2'd1;
    else if (op == 7'b1100011) e.imm = 2'd2;
    else if (op == 7'b1101111) e.imm = 2'd3;
    else                       e.imm = 2'd0;
    if (s == 9) e.aluc = 3'b001;
    else if (s == 6 || s == 7) begin
      if (f3 == 3'b000)      e.aluc = (op[5] && f7b5) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) e.aluc = 3'b101;
      else if (f3 == 3'b110) e.aluc = 3'b011;
      else if (f3 == 3'b111) e.aluc = 3'b010;
      else                   e.aluc = 3'b000;
    end
    e.sa   = (s == 1 || s == 10) ? 2'd1 : (s inside {2, 6, 7, 9}) ? 2'd2 : 2'd0;
    e.sb   = (s == 0 || s == 10) ? 2'd2 : (s inside {1, 2, 7}) ? 2'd1 : 2'd0;
    e.res  = (s == 0) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0;
    e.adr  = (s == 3 || s == 5);
    e.irw  = on && (s == 0);
    e.pcw  = on && (s == 0 || s == 10 || (s == 9 && zero));
    e.memw = on && (s == 5);
    e.regw = on && (s == 4 || s == 8);
    e.done = on && (s inside {4, 5, 8, 9, 10});
    e.ill  = on && (s == 1) && !legal_op(op);
    return e;
  endfunction

  task automatic build_seq(input logic [6:0] op, output int n, output int s[6]);
    s = '{0, 0, 0, 0, 0, 0};
    case (op)
      7'b0000011: begin s = '{0, 1, 2, 3, 4, 0}; n = 5; end
      7'b0100011: begin s = '{0, 1, 2, 5, 0, 0}; n = 4; end
      7'b0110011: begin s = '{0, 1, 6, 8, 0, 0}; n = 4; end
      7'b0010011: begin s = '{0, 1, 7, 8, 0, 0}; n = 4; end
      7'b1100011: begin s = '{0, 1, 9, 0, 0, 0}; n = 3; end
      7'b1101111: begin s = '{0, 1, 10, 0, 0, 0}; n = 3; end
      default:    begin s = '{0, 1, 0, 0, 0, 0}; n = 2; end
    endcase
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      e_cur = model(exp_state, RST_N, OP, FUNCT3, FUNCT7B5, ZERO);
      chk("STATE", STATE, e_cur.state);
      chk("PCWRITE", {3'b0, PCWRITE}, {3'b0, e_cur.pcw});
      chk("ADRSRC", {3'b0, ADRSRC}, {3'b0, e_cur.adr});
      chk("MEMWRITE", {3'b0, MEMWRITE}, {3'b0, e_cur.memw});
      chk("IRWRITE", {3'b0, IRWRITE}, {3'b0, e_cur.irw});
      chk("REGWRITE", {3'b0, REGWRITE}, {3'b0, e_cur.regw});
      chk("RESULTSRC", {2'b0, RESULTSRC}, {2'b0, e_cur.res});
      chk("ALUSRCA", {2'b0, ALUSRCA}, {2'b0, e_cur.sa});
      chk("ALUSRCB", {2'b0, ALUSRCB}, {2'b0, e_cur.sb});
      chk("IMMSRC", {2'b0, IMMSRC}, {2'b0, e_cur.imm});
      chk("ALUCONTROL", {1'b0, ALUCONTROL}, {1'b0, e_cur.aluc});
      chk("DONE", {3'b0, DONE}, {3'b0, e_cur.done});
      chk("ILLEGAL", {3'b0, ILLEGAL}, {3'b0, e_cur.ill});
    end
  end

  // Called #1 after the edge that enters FETCH; returns #1 after the edge that
  // enters the next FETCH. hand_alu (if not F) is the literal ALUCONTROL in execute/beq.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                           input logic zero, input int lat, input logic [3:0] hand_alu);
    int n;
    int s[6];
    OP = op; FUNCT3 = f3; FUNCT7B5 = f7b5; ZERO = zero;
    build_seq(op, n, s);
    chk("latency", 4'(n), 4'(lat));
    for (int i = 0; i < n; i++) begin
      exp_state = s[i];
      @(negedge CLK);
      if (hand_alu != 4'hF && s[i] inside {6, 7, 9})
        chk("alu_literal", {1'b0, ALUCONTROL}, hand_alu);
      if (s[i] == 9) chk("beq_pcwrite_literal", {3'b0, PCWRITE}, {3'b0, zero});
      if (n == 2 && s[i] == 1) chk("illegal_literal", {3'b0, ILLEGAL}, 4'd1);
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int n;
    int s[6];
    RST_N = 1'b0; OP = 7'b0000011; FUNCT3 = 3'b000; FUNCT7B5 = 1'b0; ZERO = 1'b0;
    exp_state = 0;
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 5, 4'hF);  // lw
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 4, 4'hF);  // sw
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 4, 4'h1);  // sub
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 4, 4'h3);  // or
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 4, 4'h0);  // add
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 4, 4'h0);  // addi, f7b5 ignored
    run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, 4, 4'h5);  // slti
    run_instr(7'b0010011, 3'b111, 1'b0, 1'b0, 4, 4'h2);  // andi
    run_instr(7'b0010011, 3'b100, 1'b0, 1'b0, 4, 4'h0);  // unlisted funct3
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 3, 4'h1);  // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 3, 4'h1);  // beq not taken
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 3, 4'hF);  // jal
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 2, 4'hF);  // illegal
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 2, 4'hF);  // illegal

    // lw interrupted by reset during MEMREAD.
    OP = 7'b0000011; FUNCT3 = 3'b010;
    build_seq(OP, n, s);
    for (int i = 0; i < 4; i++) begin
      exp_state = s[i];
      if (s[i] == 3) RST_N = 1'b0;
      @(negedge CLK);
      @(posedge CLK);
      #1;
    end
    exp_state = 0;
    @(negedge CLK);
    chk("reset_state_literal", STATE, 4'd0);
    chk("reset_irwrite_literal", {3'b0, IRWRITE}, 4'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("release_irwrite_literal", {3'b0, IRWRITE}, 4'd1);
    chk("release_pcwrite_literal", {3'b0, PCWRITE}, 4'd1);
    @(posedge CLK);
    #1;
    // Finish the post-release instruction from DECODE on.
    for (int i = 1; i < n; i++) begin
      exp_state = s[i];
      @(negedge CLK);
      @(posedge CLK);
      #1;
    end
    exp_state = 0;
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 4, 4'hF);
    @(negedge CLK);
    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
